// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: WB-to-store data forwarding, a DEPTH-entry store FIFO that
// drains to data memory over valid/ready, and youngest-first load lookup against queued stores.
module mem_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        st_valid,
  input  logic [ADDR_W-1:0]           st_addr,
  input  logic [DATA_W-1:0]           st_data,
  input  logic [DATA_W/8-1:0]         st_be,
  input  logic [4:0]                  st_rt,
  input  logic                        wb_regwrite,
  input  logic [4:0]                  wb_rt,
  input  logic [DATA_W-1:0]           wb_data,
  output logic                        st_stall,
  input  logic                        ld_valid,
  input  logic [ADDR_W-1:0]           ld_addr,
  output logic                        ld_hit,
  output logic [DATA_W-1:0]           ld_data,
  output logic                        ld_conflict,
  output logic                        mem_wr_valid,
  output logic [ADDR_W-1:0]           mem_wr_addr,
  output logic [DATA_W-1:0]           mem_wr_data,
  output logic [DATA_W/8-1:0]         mem_wr_be,
  input  logic                        mem_wr_ready,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        full
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Byte-offset bits are masked off so whole addresses can be compared as word addresses.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(BE_W - 1));

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [BE_W-1:0]   be_mem   [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DATA_W-1:0] eff_data;
  logic              push;
  logic              pop;
  logic              lk_found;
  logic [DATA_W-1:0] lk_data;
  logic [BE_W-1:0]   lk_be;
  logic [PTR_W-1:0]  slot;

  assign empty = (count == CNT_W'(0));
  assign full  = (count == CNT_W'(DEPTH));

  // Store data select: take the older instruction's result when it targets this store's rt.
  always_comb begin
    if (wb_regwrite && (wb_rt == st_rt) && (wb_rt != 5'd0)) begin
      eff_data = wb_data;
    end else begin
      eff_data = st_data;
    end
  end

  assign pop      = ~empty & mem_wr_ready;
  assign push     = st_valid & (~full | pop);
  assign st_stall = st_valid & full & ~mem_wr_ready;

  assign mem_wr_valid = ~empty;
  assign mem_wr_addr  = empty ? '0 : addr_mem[head];
  assign mem_wr_data  = empty ? '0 : data_mem[head];
  assign mem_wr_be    = empty ? '0 : be_mem[head];

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because unoccupied slots are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= st_addr;
      data_mem[tail] <= eff_data;
      be_mem[tail]   <= st_be;
    end
  end

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    lk_found = 1'b0;
    lk_data  = '0;
    lk_be    = '0;
    slot     = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if ((CNT_W'(i) < count) &&
          ((addr_mem[slot] & WORD_MASK) == (ld_addr & WORD_MASK))) begin
        lk_found = 1'b1;
        lk_data  = data_mem[slot];
        lk_be    = be_mem[slot];
      end
    end
  end

  assign ld_hit      = ld_valid & lk_found & (&lk_be);
  assign ld_conflict = ld_valid & lk_found & ~(&lk_be);
  assign ld_data     = ld_hit ? lk_data : '0;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed test-plan steps followed by random
// traffic, all compared against a queue-based reference model of the store buffer.
module tb_mem_store_buffer;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [3:0]    st_be;
  logic [4:0]    st_rt;
  logic          wb_regwrite;
  logic [4:0]    wb_rt;
  logic [DW-1:0] wb_data;
  logic          st_stall;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          ld_conflict;
  logic          mem_wr_valid;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [3:0]    mem_wr_be;
  logic          mem_wr_ready;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  mem_store_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_rt(st_rt),
    .wb_regwrite(wb_regwrite), .wb_rt(wb_rt), .wb_data(wb_data), .st_stall(st_stall),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .ld_conflict(ld_conflict),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .mem_wr_ready(mem_wr_ready),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    be;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] wr_log[$];
  int            passed = 0;
  int            total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = 4'h0; st_rt = 5'd0;
    wb_regwrite = 1'b0; wb_rt = 5'd0; wb_data = '0;
    ld_valid = 1'b0; ld_addr = '0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    idle();
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = be; st_rt = 5'd9;
  endtask

  task automatic load(input logic [AW-1:0] a);
    idle();
    ld_valid = 1'b1; ld_addr = a;
  endtask

  // One clock cycle: check every output against the model, then advance the model.
  task automatic step();
    ent_t          m;
    bit            found;
    bit            hit;
    bit            conf;
    bit            pop;
    bit            push;
    logic [DW-1:0] ed;
    #1;
    check("st_stall", st_stall, st_valid && q.size() == D && !mem_wr_ready);
    check("mem_wr_valid", mem_wr_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("mem_wr_addr", mem_wr_addr, q[0].a);
      check("mem_wr_data", mem_wr_data, q[0].d);
      check("mem_wr_be", mem_wr_be, q[0].be);
    end
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == D);
    found = 1'b0;
    m = '{a: '0, d: '0, be: 4'h0};
    if (ld_valid) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if ((q[i].a >> 2) == (ld_addr >> 2)) begin
          m = q[i];
          found = 1'b1;
          break;
        end
      end
    end
    hit  = found && (m.be == 4'hF);
    conf = found && (m.be != 4'hF);
    check("ld_hit", ld_hit, hit);
    check("ld_conflict", ld_conflict, conf);
    check("ld_data", ld_data, hit ? m.d : 32'h0);
    pop  = (q.size() != 0) && mem_wr_ready;
    push = st_valid && ((q.size() < D) || pop);
    ed   = (wb_regwrite && wb_rt == st_rt && wb_rt != 5'd0) ? wb_data : st_data;
    if (pop) wr_log.push_back(mem_wr_data);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{a: st_addr, d: ed, be: st_be});
    @(negedge clk);
  endtask

  initial begin
    idle();
    mem_wr_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_valid", mem_wr_valid, 1'b0);
    check("rst_stall", st_stall, 1'b0);
    check("rst_ld_hit", ld_hit, 1'b0);
    check("rst_ld_conflict", ld_conflict, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // WB forwarding
    store(32'h100, 32'h12345678, 4'hF);
    st_rt = 5'd5; wb_regwrite = 1'b1; wb_rt = 5'd5; wb_data = 32'hAAAA0001;
    step();
    store(32'h104, 32'h12345678, 4'hF);
    st_rt = 5'd0; wb_regwrite = 1'b1; wb_rt = 5'd0; wb_data = 32'hAAAA0001;
    step();
    idle();
    check("wb_fwd_data", mem_wr_data, 32'hAAAA0001);
    mem_wr_ready = 1'b1;
    step();
    check("wb_rt0_data", mem_wr_data, 32'h12345678);
    step();
    check("wb_drained", empty, 1'b1);

    // Fill and stall
    mem_wr_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      store(32'h200 + 32'(4 * i), 32'(i + 1), 4'hF);
      step();
    end
    idle();
    #1;
    check("fill_full", full, 1'b1);
    check("fill_count", count, 3'd4);
    store(32'h210, 32'h5, 4'hF);
    #1;
    check("fill_stall5", st_stall, 1'b1);
    step();
    store(32'h210, 32'h5, 4'hF);
    mem_wr_ready = 1'b1;
    #1;
    check("fill_stall_ready", st_stall, 1'b0);
    step();
    idle();
    check("fill_count_keep", count, 3'd4);
    for (int i = 0; i < D; i++) step();
    check("fill_drained", empty, 1'b1);

    // Drain order
    wr_log.delete();
    mem_wr_ready = 1'b1;
    store(32'h10, 32'h1, 4'hF); step();
    store(32'h14, 32'h2, 4'hF); step();
    store(32'h18, 32'h3, 4'hF); step();
    idle(); step();
    check("drain_n", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("drain_0", wr_log[0], 32'h1);
      check("drain_1", wr_log[1], 32'h2);
      check("drain_2", wr_log[2], 32'h3);
    end
    check("drain_empty", empty, 1'b1);

    // Load forwarding
    mem_wr_ready = 1'b0;
    store(32'h20, 32'h11, 4'hF); step();
    store(32'h20, 32'h22, 4'hF); step();
    load(32'h20);
    #1;
    check("ld_fwd_hit", ld_hit, 1'b1);
    check("ld_fwd_data", ld_data, 32'h22);
    step();
    load(32'h24);
    #1;
    check("ld_miss_hit", ld_hit, 1'b0);
    check("ld_miss_conflict", ld_conflict, 1'b0);
    step();

    // Partial conflict
    store(32'h30, 32'hBEEF, 4'b0011); step();
    load(32'h32);
    #1;
    check("partial_conflict", ld_conflict, 1'b1);
    check("partial_hit", ld_hit, 1'b0);
    step();
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    #1;
    check("partial_cleared", ld_conflict, 1'b0);
    step();

    // Reset mid-drain
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(32'h40 + 32'(4 * i), 32'(i + 7), 4'hF);
      step();
    end
    idle();
    mem_wr_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    check("rstmid_valid", mem_wr_valid, 1'b0);
    check("rstmid_count", count, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    wr_log.delete();
    for (int i = 0; i < 3; i++) step();
    check("rstmid_no_write", wr_log.size(), 0);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      idle();
      case ($urandom_range(0, 2))
        0: begin
          store(32'h60 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
                $urandom(), ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF);
          st_rt = 5'($urandom_range(0, 3));
          wb_regwrite = 1'($urandom());
          wb_rt = 5'($urandom_range(0, 3));
          wb_data = $urandom();
        end
        1: load(32'h60 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3)));
        default: idle();
      endcase
      mem_wr_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
